// File: rtl/vga_text_render.sv
// vga_text_render
//   Character-cell text renderer. Converts pixel coordinates from the VGA
//   timing generator into RGB444 pixels through a fixed 3-register pipeline:
//     T   : cell_addr registered from x_pos/y_pos
//     T+1 : font_addr registered from {char, glyph_row}
//     T+2 : glyph bit + attribute -> palette colour, registered to vga_r/g/b
//   Outputs therefore appear exactly 3 cycles after the inputs that produced
//   them. Syncs travel through the same depth so they stay aligned.
//
//   Cell entries are {attr[7:0], char[7:0]}:
//     attr[3:0] foreground (16 colours), attr[6:4] background (8 colours),
//     attr[7] blink (foreground hidden while blink_phase = 1).
//
//   Optional build macro VGA_TEXT_CURSOR_EN adds an underline cursor that
//   swaps fg/bg on the bottom two glyph rows of one cell, blinking with
//   blink_phase.
//
// Ports
//   clk, reset            pixel clock, asynchronous active-high reset
//   disp, x_pos, y_pos    visible-area flag and pixel coordinates
//   hsync_in, vsync_in    syncs from the timing generator
//   frame_start           one-cycle pulse per frame (drives blink timing)
//   cell_addr, cell_data  text-buffer read port (data valid 1 cycle later)
//   font_addr, font_data  font memory read port (data valid 1 cycle later)
//   vga_r, vga_g, vga_b   registered RGB444 colour
//   hsync_out, vsync_out  syncs delayed by 3 cycles
//   cursor_en, cursor_col, cursor_row   (VGA_TEXT_CURSOR_EN only)

module vga_text_render #(
  parameter int H_DISP       = 1280,
  parameter int V_DISP       = 1024,
  parameter int X_WIDTH      = 11,
  parameter int Y_WIDTH      = 11,
  parameter int ADDR_WIDTH   = 16,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            disp,
  input  logic [X_WIDTH-1:0]              x_pos,
  input  logic [Y_WIDTH-1:0]              y_pos,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            frame_start,
`ifdef VGA_TEXT_CURSOR_EN
  input  logic                            cursor_en,
  input  logic [X_WIDTH-1:0]              cursor_col,
  input  logic [Y_WIDTH-1:0]              cursor_row,
`endif
  output logic [ADDR_WIDTH-1:0]           cell_addr,
  input  logic [15:0]                     cell_data,
  output logic [8+$clog2(GLYPH_H)-1:0]    font_addr,
  input  logic [GLYPH_W-1:0]              font_data,
  output logic [3:0]                      vga_r,
  output logic [3:0]                      vga_g,
  output logic [3:0]                      vga_b,
  output logic                            hsync_out,
  output logic                            vsync_out
);

  localparam int GW_BITS = $clog2(GLYPH_W);
  localparam int GH_BITS = $clog2(GLYPH_H);
  localparam int COLS    = H_DISP / GLYPH_W;
  localparam int BW      = $clog2(BLINK_FRAMES + 1);

  // Palette: i[2:0] selects r/g/b components, i[3] is intensity.
  function automatic logic [11:0] palette(input logic [3:0] i);
    logic [3:0] on_lvl;
    logic [3:0] off_lvl;
    on_lvl  = i[3] ? 4'hF : 4'hA;
    off_lvl = i[3] ? 4'h5 : 4'h0;
    return {i[2] ? on_lvl : off_lvl,
            i[1] ? on_lvl : off_lvl,
            i[0] ? on_lvl : off_lvl};
  endfunction

  // Stage-1 shadows (valid while cell_data is being returned)
  logic               s1_disp, s1_hs, s1_vs;
  logic [GW_BITS-1:0] s1_xbit;
  logic [GH_BITS-1:0] s1_grow;
  // Stage-2 shadows (valid while font_data is being returned)
  logic               s2_disp, s2_hs, s2_vs;
  logic [GW_BITS-1:0] s2_xbit;
  logic [7:0]         s2_attr;

  logic [BW-1:0]      blink_cnt;
  logic               blink_phase;

  logic [ADDR_WIDTH-1:0] addr_next;
  logic [11:0]           rgb_next;

  // Arithmetic at ADDR_WIDTH bits gives the modulo-2^ADDR_WIDTH wrap directly.
  always_comb begin
    addr_next = ADDR_WIDTH'(y_pos >> GH_BITS) * ADDR_WIDTH'(COLS)
              + ADDR_WIDTH'(x_pos >> GW_BITS);
  end

`ifdef VGA_TEXT_CURSOR_EN
  logic [X_WIDTH-GW_BITS-1:0] s1_col, s2_col;
  logic [Y_WIDTH-GH_BITS-1:0] s1_row, s2_row;
  logic [GH_BITS-1:0]         s2_grow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_col  <= '0;
      s1_row  <= '0;
      s2_col  <= '0;
      s2_row  <= '0;
      s2_grow <= '0;
    end else begin
      s1_col  <= x_pos[X_WIDTH-1:GW_BITS];
      s1_row  <= y_pos[Y_WIDTH-1:GH_BITS];
      s2_col  <= s1_col;
      s2_row  <= s1_row;
      s2_grow <= s1_grow;
    end
  end
`endif

  // NOTE: every pipeline stage uses non-blocking assignments so each register
  // samples the previous stage's value from before the edge; blocking here
  // would collapse the stages and break the 3-cycle alignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cell_addr <= '0;
      s1_disp   <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_xbit   <= '0;
      s1_grow   <= '0;
      font_addr <= '0;
      s2_disp   <= 1'b0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      s2_xbit   <= '0;
      s2_attr   <= '0;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      // Stage 0
      cell_addr <= addr_next;
      s1_disp   <= disp;
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      s1_xbit   <= x_pos[GW_BITS-1:0];
      s1_grow   <= y_pos[GH_BITS-1:0];
      // Stage 1
      font_addr <= {cell_data[7:0], s1_grow};
      s2_disp   <= s1_disp;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      s2_xbit   <= s1_xbit;
      s2_attr   <= cell_data[15:8];
      // Stage 2 / output
      {vga_r, vga_g, vga_b} <= s2_disp ? rgb_next : 12'h000;
      hsync_out <= s2_hs;
      vsync_out <= s2_vs;
    end
  end

  // Colour selection for the pixel currently leaving stage 2.
  always_comb begin
    logic [3:0]         fg_idx;
    logic [3:0]         bg_idx;
    logic [3:0]         tmp_idx;
    logic [GW_BITS-1:0] bit_idx;
    logic               lit;
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    fg_idx  = s2_attr[3:0];
    bg_idx  = {1'b0, s2_attr[6:4]};
    tmp_idx = 4'h0;
    bit_idx = GW_BITS'(GLYPH_W - 1) - s2_xbit;
    lit     = font_data[bit_idx] && !(s2_attr[7] && blink_phase);
`ifdef VGA_TEXT_CURSOR_EN
    if (cursor_en && !blink_phase &&
        (X_WIDTH'(s2_col) == cursor_col) && (Y_WIDTH'(s2_row) == cursor_row) &&
        (s2_grow >= GH_BITS'(GLYPH_H - 2))) begin
      tmp_idx = fg_idx;
      fg_idx  = bg_idx;
      bg_idx  = tmp_idx;
    end
`endif
    rgb_next = palette(lit ? fg_idx : bg_idx);
  end

  // Blink timebase: blink_phase toggles every BLINK_FRAMES frame_start pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render (BLINK_FRAMES = 2). The text-buffer and
// font memories are modelled as registers the bench sets per vector; every
// expected value is hand-computed from the palette and address rules.
// Build with +define+VGA_TEXT_CURSOR_EN to include the cursor vectors.

module tb_vga_text_render;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  logic        hsync_in;
  logic        vsync_in;
  logic        frame_start;
  logic [15:0] cell_addr;
  logic [15:0] cell_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_out;
  logic        vsync_out;
`ifdef VGA_TEXT_CURSOR_EN
  logic        cursor_en;
  logic [10:0] cursor_col;
  logic [10:0] cursor_row;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  vga_text_render #(
    .H_DISP(1280), .V_DISP(1024), .X_WIDTH(11), .Y_WIDTH(11),
    .ADDR_WIDTH(16), .GLYPH_W(8), .GLYPH_H(16), .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .disp       (disp),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .frame_start(frame_start),
`ifdef VGA_TEXT_CURSOR_EN
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
`endif
    .cell_addr  (cell_addr),
    .cell_data  (cell_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  always #5 clk = ~clk;

  wire [11:0] rgb = {vga_r, vga_g, vga_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    disp        = 1'b1;
    x_pos       = 11'd0;
    y_pos       = 11'd0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    frame_start = 1'b1;        // coincides with reset: must not count
    cell_data   = 16'h1E41;    // fg E (yellow bright), bg 1 (blue)
    font_data   = 8'hFF;
`ifdef VGA_TEXT_CURSOR_EN
    cursor_en   = 1'b0;
    cursor_col  = 11'd2;
    cursor_row  = 11'd2;
`endif

    // Reset state
    #12;
    check("rst_cell_addr", 32'(cell_addr), 32'h0);
    check("rst_font_addr", 32'(font_addr), 32'h0);
    check("rst_rgb",       32'(rgb),       32'h0);
    check("rst_hsync",     32'(hsync_out), 32'h0);
    check("rst_vsync",     32'(vsync_out), 32'h0);

    // Release mid-cycle; pipeline fills over 3 edges
    tick(1);
    frame_start = 1'b0;
    reset       = 1'b0;
    tick(1);
    check("fill1_cell_addr", 32'(cell_addr), 32'h0);
    check("fill1_rgb",       32'(rgb),       32'h0);
    tick(1);
    check("fill2_rgb",       32'(rgb),       32'h0);
    tick(1);
    check("fill3_rgb",       32'(rgb),       32'hFF5);

    // Address generation: x=17,y=35 -> row 2, col 2 -> 322; glyph row 3
    x_pos = 11'd17;
    y_pos = 11'd35;
    tick(1);
    check("addr_322",  32'(cell_addr), 32'd322);
    tick(1);
    check("font_addr", 32'(font_addr), 32'h413);

    // Glyph bit selection and exact latency
    font_data = 8'h80;
    x_pos     = 11'd16;
    tick(3);
    check("px0_fg_yellow", 32'(rgb), 32'hFF5);
    x_pos = 11'd17;
    tick(2);
    check("px1_latency2", 32'(rgb), 32'hFF5);
    tick(1);
    check("px1_bg_blue",  32'(rgb), 32'h00A);

    // Blink: attr 0x8F, BLINK_FRAMES=2
    cell_data = 16'h8F41;
    font_data = 8'hFF;
    x_pos     = 11'd16;
    tick(3);
    check("blink_phase0", 32'(rgb), 32'hFFF);
    pulse_frame();
    tick(3);
    check("blink_one_pulse", 32'(rgb), 32'hFFF);
    pulse_frame();
    tick(3);
    check("blink_phase1", 32'(rgb), 32'h000);
    pulse_frame();
    pulse_frame();
    tick(3);
    check("blink_back0", 32'(rgb), 32'hFFF);

    // Blanking and sync delay
    cell_data = 16'h1E41;
    disp      = 1'b0;
    tick(3);
    check("blank_rgb", 32'(rgb), 32'h000);
    hsync_in = 1'b1;
    tick(1);
    hsync_in = 1'b0;
    check("hs_d1", 32'(hsync_out), 32'h0);
    tick(1);
    check("hs_d2", 32'(hsync_out), 32'h0);
    tick(1);
    check("hs_d3", 32'(hsync_out), 32'h1);
    tick(1);
    check("hs_d4", 32'(hsync_out), 32'h0);
    vsync_in = 1'b1;
    tick(1);
    vsync_in = 1'b0;
    tick(1);
    check("vs_d2", 32'(vsync_out), 32'h0);
    tick(1);
    check("vs_d3", 32'(vsync_out), 32'h1);

    // Last column / last row / last glyph row and rightmost pixel
    disp      = 1'b1;
    x_pos     = 11'd1279;
    y_pos     = 11'd1023;
    cell_data = 16'h0241;      // fg 2 (green), bg 0
    font_data = 8'h01;
    tick(1);
    check("last_cell_addr", 32'(cell_addr), 32'd10239);
    tick(1);
    check("last_font_addr", 32'(font_addr), 32'h41F);
    tick(1);
    check("last_rgb",       32'(rgb),       32'h0A0);

    // Reset mid-frame: immediate flush, black for 3 cycles after release
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_rgb",       32'(rgb),       32'h0);
    check("mid_rst_cell_addr", 32'(cell_addr), 32'h0);
    check("mid_rst_font_addr", 32'(font_addr), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(1);
    check("mid_fill1", 32'(rgb), 32'h0);
    tick(1);
    check("mid_fill2", 32'(rgb), 32'h0);
    tick(1);
    check("mid_fill3", 32'(rgb), 32'h0A0);

`ifdef VGA_TEXT_CURSOR_EN
    // Cursor at (2,2): x=16 is col 2, y=47 is row 2 glyph row 15
    cell_data = 16'h0741;
    font_data = 8'h00;
    x_pos     = 11'd16;
    y_pos     = 11'd47;
    cursor_en = 1'b1;
    tick(3);
    check("cursor_row15", 32'(rgb), 32'hAAA);
    y_pos = 11'd45;
    tick(3);
    check("cursor_row13", 32'(rgb), 32'h000);
    y_pos     = 11'd47;
    cursor_en = 1'b0;
    tick(3);
    check("cursor_off", 32'(rgb), 32'h000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
